// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared types and constants for the fetch-path sequencer.
//   - state_t        : sequencer states (SKIP exists only with CTRL_SEQ_SKIP_EN)
//   - instr_class_t  : instruction classes produced by ctrl_seq_decode
//   - opcode match/mask constants (RJMP, BRBx, IJMP, JMP, LPM, two-word set)
//   - mux-select encodings for mode12K and modeAddZA
// Build option: CTRL_SEQ_SKIP_EN (enables the SKIP state).
package ctrl_seq_pkg;

`ifdef CTRL_SEQ_SKIP_EN
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_JMP2  = 2'd2,
        ST_SKIP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_JMP2  = 2'd2
    } state_t;
`endif

    typedef enum logic [2:0] {
        CLS_OTHER = 3'd0,
        CLS_RJMP  = 3'd1,
        CLS_BRBX  = 3'd2,
        CLS_IJMP  = 3'd3,
        CLS_JMP   = 3'd4,
        CLS_LPM   = 3'd5
    } instr_class_t;

    // Opcode classification constants
    localparam logic [15:0] RJMP_MASK   = 16'hF000;
    localparam logic [15:0] RJMP_MATCH  = 16'hC000;
    localparam logic [15:0] BRBX_MASK   = 16'hF800;
    localparam logic [15:0] BRBX_MATCH  = 16'hF000;
    localparam logic [15:0] IJMP_OP     = 16'h9409;
    localparam logic [15:0] JMP_MASK    = 16'hFE0E;
    localparam logic [15:0] JMP_MATCH   = 16'h940C;
    localparam logic [15:0] LPM_OP      = 16'h95C8;
    // Two-word opcodes: JMP/CALL and LDS/STS
    localparam logic [15:0] TW_JC_MASK  = 16'hFE0C;
    localparam logic [15:0] TW_JC_MATCH = 16'h940C;
    localparam logic [15:0] TW_LS_MASK  = 16'hFC0F;
    localparam logic [15:0] TW_LS_MATCH = 16'h9000;

    // Adder select
    localparam logic [1:0] M12K_PLUS1 = 2'b00;
    localparam logic [1:0] M12K_PLUS2 = 2'b01;
    localparam logic [1:0] M12K_PLUSK = 2'b10;

    // Next-PC select
    localparam logic [1:0] MAZA_ADDER = 2'b00;
    localparam logic [1:0] MAZA_Z     = 2'b10;
    localparam logic [1:0] MAZA_A     = 2'b11;

    function automatic logic is_two_word(input logic [15:0] w);
        return ((w & TW_JC_MASK) == TW_JC_MATCH) || ((w & TW_LS_MASK) == TW_LS_MATCH);
    endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// ctrl_seq_decode: pure combinational instruction classifier.
// Ports:
//   i_word      in  16  instruction word to classify
//   o_class     out  3  instruction class (instr_class_t)
//   o_K         out 16  sign-extended relative offset (RJMP k12, BRBx k7), else 0
//   o_two_word  out  1  word is the first half of a two-word opcode
module ctrl_seq_decode
    import ctrl_seq_pkg::*;
(
    input  logic [15:0]  i_word,
    output instr_class_t o_class,
    output logic [15:0]  o_K,
    output logic         o_two_word
);

    always_comb begin
        o_class = CLS_OTHER;
        o_K     = '0;
        if ((i_word & RJMP_MASK) == RJMP_MATCH) begin
            o_class = CLS_RJMP;
            o_K     = {{4{i_word[11]}}, i_word[11:0]};
        end else if ((i_word & BRBX_MASK) == BRBX_MATCH) begin
            o_class = CLS_BRBX;
            o_K     = {{9{i_word[9]}}, i_word[9:3]};
        end else if (i_word == IJMP_OP) begin
            o_class = CLS_IJMP;
        end else if ((i_word & JMP_MASK) == JMP_MATCH) begin
            o_class = CLS_JMP;
        end else if (i_word == LPM_OP) begin
            o_class = CLS_LPM;
        end
    end

    assign o_two_word = is_two_word(i_word);

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: instruction-cycle sequencer for the fetch path.
// Drives PC/IR load strobes and the adder / next-PC / PM-address selects,
// and gates datapath execution with a one-cycle strobe.
// Ports:
//   i_clk, i_reset_n        clock (rising edge), async active-low reset
//   i_IR [15:0]             current instruction register
//   i_PMDATA [15:0]         program-memory read data
//   i_sreg [7:0]            status flags
//   i_skip                  skip condition, valid in EXEC
//   i_stall                 freeze: suppresses loads/strobes and holds state
//   o_mode12K [1:0]         adder select (00 +1, 01 +2, 10 +K)
//   o_modeAddZA [1:0]       next-PC select (0x adder, 10 Z, 11 A)
//   o_modePCZ               PM address select (0 PC, 1 Z)
//   o_loadIR, o_loadPC      load strobes
//   o_K [15:0]              sign-extended branch offset
//   o_A [15:0]              latched absolute jump target
//   o_exec, o_lpm           datapath execute / LPM data-valid strobes
// Build option: CTRL_SEQ_SKIP_EN adds the SKIP state and honours i_skip.
module ctrl_sequencer
    import ctrl_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_IR,
    input  logic [15:0] i_PMDATA,
    input  logic [7:0]  i_sreg,
    input  logic        i_skip,
    input  logic        i_stall,
    output logic [1:0]  o_mode12K,
    output logic [1:0]  o_modeAddZA,
    output logic        o_modePCZ,
    output logic        o_loadIR,
    output logic        o_loadPC,
    output logic [15:0] o_K,
    output logic [15:0] o_A,
    output logic        o_exec,
    output logic        o_lpm
);

    state_t       state_q, state_d;
    logic [15:0]  a_q, a_d;

    instr_class_t ir_class, pm_class;
    logic [15:0]  ir_k, pm_k;
    logic         ir_two_word, pm_two_word;

    logic [1:0]   mode12k, mode_add_za;
    logic         mode_pcz, load_ir, load_pc, exec, lpm;

    ctrl_seq_decode u_dec_ir (
        .i_word     (i_IR),
        .o_class    (ir_class),
        .o_K        (ir_k),
        .o_two_word (ir_two_word)
    );

    // Second classifier instance looks ahead at the word after a skipped
    // instruction; only its two-word flag matters.
    ctrl_seq_decode u_dec_pm (
        .i_word     (i_PMDATA),
        .o_class    (pm_class),
        .o_K        (pm_k),
        .o_two_word (pm_two_word)
    );

`ifdef CTRL_SEQ_SKIP_EN
    logic unused_bits;
    assign unused_bits = ^{pm_class, pm_k, ir_two_word};
`else
    logic unused_bits;
    assign unused_bits = ^{pm_class, pm_k, ir_two_word, pm_two_word, i_skip};
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_FETCH;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        mode12k     = M12K_PLUS1;
        mode_add_za = MAZA_ADDER;
        mode_pcz    = 1'b0;
        load_ir     = 1'b0;
        load_pc     = 1'b0;
        exec        = 1'b0;
        lpm         = 1'b0;

        case (state_q)
            ST_FETCH: begin
                load_ir = 1'b1;
                load_pc = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (ir_class)
                    CLS_RJMP: begin
                        mode12k = M12K_PLUSK;
                        load_pc = 1'b1;
                    end
                    CLS_BRBX: begin
                        // Bit 10 set = BRBC (branch on clear), so take when flag differs
                        mode12k = M12K_PLUSK;
                        load_pc = (i_sreg[i_IR[2:0]] != i_IR[10]);
                    end
                    CLS_IJMP: begin
                        mode_add_za = MAZA_Z;
                        load_pc     = 1'b1;
                    end
                    CLS_JMP: begin
                        // PC already addresses the second word; capture it as the target
                        a_d     = i_PMDATA;
                        state_d = ST_JMP2;
                    end
                    CLS_LPM: begin
                        mode_pcz = 1'b1;
                        lpm      = 1'b1;
                    end
                    default: begin
                        exec = 1'b1;
`ifdef CTRL_SEQ_SKIP_EN
                        if (i_skip) state_d = ST_SKIP;
`endif
                    end
                endcase
            end
            ST_JMP2: begin
                mode_add_za = MAZA_A;
                load_pc     = 1'b1;
                state_d     = ST_FETCH;
            end
`ifdef CTRL_SEQ_SKIP_EN
            ST_SKIP: begin
                load_pc = 1'b1;
                mode12k = pm_two_word ? M12K_PLUS2 : M12K_PLUS1;
                state_d = ST_FETCH;
            end
`endif
            default: state_d = ST_FETCH;
        endcase

        // Stall freezes state and target but leaves the selects decoded
        if (i_stall) begin
            load_ir = 1'b0;
            load_pc = 1'b0;
            exec    = 1'b0;
            lpm     = 1'b0;
            state_d = state_q;
            a_d     = a_q;
        end
    end

    assign o_mode12K   = i_reset_n ? mode12k     : '0;
    assign o_modeAddZA = i_reset_n ? mode_add_za : '0;
    assign o_modePCZ   = i_reset_n & mode_pcz;
    assign o_loadIR    = i_reset_n & load_ir;
    assign o_loadPC    = i_reset_n & load_pc;
    assign o_exec      = i_reset_n & exec;
    assign o_lpm       = i_reset_n & lpm;
    assign o_K         = i_reset_n ? ir_k : '0;
    assign o_A         = a_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
module tb_ctrl_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [15:0] i_IR;
    logic [15:0] i_PMDATA;
    logic [7:0]  i_sreg;
    logic        i_skip;
    logic        i_stall;
    logic [1:0]  o_mode12K;
    logic [1:0]  o_modeAddZA;
    logic        o_modePCZ;
    logic        o_loadIR;
    logic        o_loadPC;
    logic [15:0] o_K;
    logic [15:0] o_A;
    logic        o_exec;
    logic        o_lpm;

    ctrl_sequencer dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_IR        (i_IR),
        .i_PMDATA    (i_PMDATA),
        .i_sreg      (i_sreg),
        .i_skip      (i_skip),
        .i_stall     (i_stall),
        .o_mode12K   (o_mode12K),
        .o_modeAddZA (o_modeAddZA),
        .o_modePCZ   (o_modePCZ),
        .o_loadIR    (o_loadIR),
        .o_loadPC    (o_loadPC),
        .o_K         (o_K),
        .o_A         (o_A),
        .o_exec      (o_exec),
        .o_lpm       (o_lpm)
    );

    always #5 i_clk = ~i_clk;

`ifdef CTRL_SEQ_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [15:0] a_model = '0;

    // One expected cycle of an instruction (before any stall masking)
    typedef struct {
        logic [8:0]  sig;   // {mode12K, modeAddZA, modePCZ, loadIR, loadPC, exec, lpm}
        bit          k_chk;
        logic [15:0] k;
        logic [15:0] pm;
    } cyc_t;

    function automatic logic [8:0] pk(input int m12, input int mza, input bit pcz,
                                      input bit lir, input bit lpc, input bit ex, input bit lp);
        return {2'(m12), 2'(mza), pcz, lir, lpc, ex, lp};
    endfunction

    function automatic logic [8:0] obs_sig();
        return {o_mode12K, o_modeAddZA, o_modePCZ, o_loadIR, o_loadPC, o_exec, o_lpm};
    endfunction

    function automatic bit two_word(input logic [15:0] w);
        return ((w & 16'hFE0C) == 16'h940C) || ((w & 16'hFC0F) == 16'h9000);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one whole instruction from FETCH and checks every cycle against
    // the architectural expectation; stalls may be inserted before any cycle.
    task automatic do_instr(input logic [15:0] ir, input logic [7:0] sreg,
                            input logic [15:0] pm_exec, input logic [15:0] pm_skip,
                            input logic skip, input int exec_stalls, input bit rnd_stalls);
        cyc_t q[$];
        cyc_t e;
        int   k;
        bit   is_jmp;
        bit   taken;
        is_jmp = 1'b0;

        e.sig = pk(0, 0, 0, 1, 1, 0, 0); e.k_chk = 0; e.k = '0; e.pm = 16'($urandom);
        q.push_back(e);

        e.sig = pk(0, 0, 0, 0, 0, 0, 0); e.k_chk = 0; e.k = '0; e.pm = pm_exec;
        if ((ir & 16'hF000) == 16'hC000) begin
            k = int'(ir & 16'h0FFF);
            if (k >= 2048) k -= 4096;
            e.sig = pk(2, 0, 0, 0, 1, 0, 0); e.k_chk = 1; e.k = 16'(k);
            q.push_back(e);
        end else if ((ir & 16'hF800) == 16'hF000) begin
            k = int'((ir >> 3) & 16'h007F);
            if (k >= 64) k -= 128;
            taken = (((sreg >> ir[2:0]) & 8'd1) != {7'd0, ir[10]});
            e.sig = pk(2, 0, 0, 0, taken, 0, 0); e.k_chk = 1; e.k = 16'(k);
            q.push_back(e);
        end else if (ir == 16'h9409) begin
            e.sig = pk(0, 2, 0, 0, 1, 0, 0);
            q.push_back(e);
        end else if ((ir & 16'hFE0E) == 16'h940C) begin
            is_jmp = 1'b1;
            q.push_back(e);
            e.sig = pk(0, 3, 0, 0, 1, 0, 0); e.pm = 16'($urandom);
            q.push_back(e);
        end else if (ir == 16'h95C8) begin
            e.sig = pk(0, 0, 1, 0, 0, 0, 1);
            q.push_back(e);
        end else begin
            e.sig = pk(0, 0, 0, 0, 0, 1, 0);
            q.push_back(e);
            if (SKIP_EN && skip) begin
                e.sig = pk(two_word(pm_skip) ? 1 : 0, 0, 0, 0, 1, 0, 0); e.pm = pm_skip;
                q.push_back(e);
            end
        end

        foreach (q[c]) begin
            int n;
            n = (c == 1) ? exec_stalls : 0;
            if (rnd_stalls && $urandom_range(0, 3) == 0) n += int'($urandom_range(1, 2));
            for (int s = 0; s <= n; s++) begin
                i_IR = ir; i_sreg = sreg; i_PMDATA = q[c].pm; i_skip = skip;
                i_stall = (s < n);
                @(negedge i_clk);
                check($sformatf("ir%h cyc%0d st%0d sig", ir, c, s), {7'd0, obs_sig()},
                      {7'd0, (s < n) ? (q[c].sig & 9'h1F0) : q[c].sig});
                if (q[c].k_chk) check($sformatf("ir%h K", ir), o_K, q[c].k);
                check($sformatf("ir%h cyc%0d A", ir, c), o_A, a_model);
                @(posedge i_clk); #1;
            end
            if (is_jmp && c == 1) a_model = pm_exec;
        end
        i_stall = 1'b0;
    endtask

    function automatic logic [15:0] rnd_ir();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 7))
            0: return 16'hC000 | (r & 16'h0FFF);
            1: return 16'hF000 | (r & 16'h07FF);
            2: return 16'h9409;
            3: return 16'h940C | (r & 16'h01F1);
            4: return 16'h95C8;
            5: return 16'h1000 | (r & 16'h03FF);
            default: return r;
        endcase
    endfunction

    function automatic logic [15:0] rnd_pm();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 2))
            0: return 16'h940C | (r & 16'h01F3);
            1: return 16'h9000 | (r & 16'h03F0);
            default: return r;
        endcase
    endfunction

    initial begin
        i_reset_n = 1'b0; i_IR = 16'hCFFE; i_PMDATA = 16'h1234;
        i_sreg = 8'hFF; i_skip = 1'b1; i_stall = 1'b0;

        // Reset: everything quiet, target cleared
        repeat (2) begin
            @(negedge i_clk);
            check("rst sig", {7'd0, obs_sig()}, 16'h0000);
            check("rst K", o_K, 16'h0000);
            check("rst A", o_A, 16'h0000);
        end
        @(posedge i_clk); #1;
        i_reset_n = 1'b1; i_skip = 1'b0;

        // Directed steps
        do_instr(16'h0000, 8'h00, 16'h0000, 16'h0000, 1'b0, 0, 1'b0);   // NOP
        do_instr(16'hCFFE, 8'h00, 16'h0000, 16'h0000, 1'b0, 0, 1'b0);   // RJMP -2
        do_instr(16'hF001, 8'h02, 16'h0000, 16'h0000, 1'b0, 0, 1'b0);   // BRBS 1 taken
        do_instr(16'hF001, 8'h00, 16'h0000, 16'h0000, 1'b0, 0, 1'b0);   // BRBS 1 not taken
        do_instr(16'hF7F9, 8'h00, 16'h0000, 16'h0000, 1'b0, 0, 1'b0);   // BRBC 1, k=-1
        do_instr(16'h9409, 8'h00, 16'h0000, 16'h0000, 1'b0, 0, 1'b0);   // IJMP
        do_instr(16'h940C, 8'h00, 16'h1234, 16'h0000, 1'b0, 0, 1'b0);   // JMP 0x1234
        do_instr(16'h1000, 8'h00, 16'h0000, 16'h940E, 1'b1, 0, 1'b0);   // skip over two-word
        do_instr(16'h1000, 8'h00, 16'h0000, 16'h0000, 1'b1, 0, 1'b0);   // skip over one-word
        do_instr(16'h95C8, 8'h00, 16'h0000, 16'h0000, 1'b0, 3, 1'b0);   // LPM, 3 stalls in EXEC
        do_instr(16'h940C, 8'h00, 16'hA5C3, 16'h0000, 1'b0, 2, 1'b0);   // JMP, stalled EXEC

        // Reset in the middle of a JMP aborts it and clears the target
        i_IR = 16'h940C; i_PMDATA = 16'hBEEF; i_stall = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("mid JMP2 A", o_A, 16'hBEEF);
        check("mid JMP2 sig", {7'd0, obs_sig()}, {7'd0, pk(0, 3, 0, 0, 1, 0, 0)});
        i_reset_n = 1'b0;
        #1;
        check("abort sig", {7'd0, obs_sig()}, 16'h0000);
        check("abort A", o_A, 16'h0000);
        a_model = '0;
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        do_instr(16'h0000, 8'h00, 16'h0000, 16'h0000, 1'b0, 0, 1'b0);

        // Randomized instruction stream with random stalls
        for (int i = 0; i < 300; i++) begin
            do_instr(rnd_ir(), 8'($urandom), 16'($urandom), rnd_pm(),
                     1'($urandom_range(0, 1)), 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
